// File: rtl/sata_device_oob_controller_pkg.sv
// rtl/sata_device_oob_controller_pkg.sv - SATA primitives and OOB timeout defaults shared by host and device controllers
package sata_device_oob_controller_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;

    localparam logic [31:0] DEF_INIT_TIMEOUT    = 32'h0000_00A2;
    localparam logic [31:0] DEF_WAKE_TX_TIMEOUT = 32'h0000_009B;
    localparam logic [31:0] DEF_WAKE_TIMEOUT    = 32'h0002_03AD;
    localparam logic [31:0] DEF_ALIGN_TIMEOUT   = 32'h0002_03AD;
    localparam int          DEF_ALIGN_LOCK      = 3;

    // An ALIGN only counts when some byte is flagged K and the comma aligner is locked.
    function automatic logic is_align(input logic [31:0] din, input logic [3:0] is_k,
                                      input logic byte_aligned);
        return (is_k != 4'h0) && (din == PRIM_ALIGN) && byte_aligned;
    endfunction

endpackage

// File: rtl/sata_device_oob_controller_if.sv
// rtl/sata_device_oob_controller_if.sv - phy-facing signal bundle of the device OOB controller
interface sata_device_oob_controller_if;
    logic        platform_ready;
    logic        comm_reset_detect;
    logic        comm_wake_detect;
    logic        tx_oob_complete;
    logic [31:0] rx_din;
    logic [3:0]  rx_is_k;
    logic        rx_byte_is_aligned;
    logic        tx_comm_init;
    logic        tx_comm_wake;
    logic [31:0] tx_dout;
    logic        tx_is_k;
    logic        tx_set_elec_idle;
    logic        linkup;
    logic [3:0]  lax_state;

    modport slave (
        input  platform_ready, comm_reset_detect, comm_wake_detect, tx_oob_complete,
               rx_din, rx_is_k, rx_byte_is_aligned,
        output tx_comm_init, tx_comm_wake, tx_dout, tx_is_k, tx_set_elec_idle,
               linkup, lax_state
    );

    modport master (
        output platform_ready, comm_reset_detect, comm_wake_detect, tx_oob_complete,
               rx_din, rx_is_k, rx_byte_is_aligned,
        input  tx_comm_init, tx_comm_wake, tx_dout, tx_is_k, tx_set_elec_idle,
               linkup, lax_state
    );
endinterface

// File: rtl/sata_device_oob_controller.sv
// rtl/sata_device_oob_controller.sv - device-side OOB responder: COMRESET/COMINIT, COMWAKE, ALIGN lock, SYNC
module sata_device_oob_controller
    import sata_device_oob_controller_pkg::*;
#(
    parameter logic [31:0] INIT_TIMEOUT    = DEF_INIT_TIMEOUT,
    parameter logic [31:0] WAKE_TX_TIMEOUT = DEF_WAKE_TX_TIMEOUT,
    parameter logic [31:0] WAKE_TIMEOUT    = DEF_WAKE_TIMEOUT,
    parameter logic [31:0] ALIGN_TIMEOUT   = DEF_ALIGN_TIMEOUT,
    parameter int          ALIGN_LOCK      = DEF_ALIGN_LOCK
) (
    input  logic                          clk,
    input  logic                          rst,
    sata_device_oob_controller_if.slave   phy
);

    typedef enum logic [3:0] {
        IDLE          = 4'h0,
        WAIT_NO_RESET = 4'h1,
        SEND_INIT     = 4'h2,
        WAIT_WAKE     = 4'h3,
        WAIT_NO_WAKE  = 4'h4,
        SEND_WAKE     = 4'h5,
        SEND_ALIGN    = 4'h6,
        READY         = 4'h7
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(ALIGN_LOCK - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_timer, w_timer_nxt;
    logic [3:0]  r_align_cnt, w_align_cnt_nxt;
    logic        r_tx_comm_init, w_tx_comm_init_nxt;
    logic        r_tx_comm_wake, w_tx_comm_wake_nxt;
    logic [31:0] r_tx_dout, w_tx_dout_nxt;
    logic        r_tx_is_k, w_tx_is_k_nxt;
    logic        r_elec_idle, w_elec_idle_nxt;
    logic        r_linkup, w_linkup_nxt;
    logic        w_timeout;
    logic        w_align_det;

    assign w_timeout   = (r_timer == 32'd0);
    assign w_align_det = is_align(phy.rx_din, phy.rx_is_k, phy.rx_byte_is_aligned);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_timer        <= 32'd0;
            r_align_cnt    <= 4'd0;
            r_tx_comm_init <= 1'b0;
            r_tx_comm_wake <= 1'b0;
            r_tx_dout      <= 32'd0;
            r_tx_is_k      <= 1'b0;
            r_elec_idle    <= 1'b1;
            r_linkup       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= w_timer_nxt;
            r_align_cnt    <= w_align_cnt_nxt;
            r_tx_comm_init <= w_tx_comm_init_nxt;
            r_tx_comm_wake <= w_tx_comm_wake_nxt;
            r_tx_dout      <= w_tx_dout_nxt;
            r_tx_is_k      <= w_tx_is_k_nxt;
            r_elec_idle    <= w_elec_idle_nxt;
            r_linkup       <= w_linkup_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_timer_nxt        = (r_timer != 32'd0) ? r_timer - 32'd1 : 32'd0;
        w_align_cnt_nxt    = r_align_cnt;
        w_tx_comm_init_nxt = 1'b0;
        w_tx_comm_wake_nxt = 1'b0;
        w_tx_dout_nxt      = r_tx_dout;
        w_tx_is_k_nxt      = 1'b0;
        w_elec_idle_nxt    = r_elec_idle;
        w_linkup_nxt       = r_linkup;

        case (r_state)
            IDLE: begin
                w_elec_idle_nxt = 1'b1;
                w_linkup_nxt    = 1'b0;
                if (phy.platform_ready && phy.comm_reset_detect) w_state_nxt = WAIT_NO_RESET;
            end
            WAIT_NO_RESET: begin
                if (!phy.comm_reset_detect) begin
                    w_state_nxt        = SEND_INIT;
                    w_tx_comm_init_nxt = 1'b1;
                    w_timer_nxt        = INIT_TIMEOUT;
                end
            end
            SEND_INIT: begin
                if (phy.tx_oob_complete || w_timeout) begin
                    w_state_nxt = WAIT_WAKE;
                    w_timer_nxt = WAKE_TIMEOUT;
                end
            end
            WAIT_WAKE: begin
                if (phy.comm_wake_detect) w_state_nxt = WAIT_NO_WAKE;
                else if (w_timeout)       w_state_nxt = IDLE;
            end
            WAIT_NO_WAKE: begin
                if (!phy.comm_wake_detect) begin
                    w_state_nxt        = SEND_WAKE;
                    w_tx_comm_wake_nxt = 1'b1;
                    w_timer_nxt        = WAKE_TX_TIMEOUT;
                end
            end
            SEND_WAKE: begin
                if (phy.tx_oob_complete || w_timeout) begin
                    w_state_nxt     = SEND_ALIGN;
                    w_timer_nxt     = ALIGN_TIMEOUT;
                    w_align_cnt_nxt = 4'd0;
                end
            end
            SEND_ALIGN: begin
                w_elec_idle_nxt = 1'b0;
                w_tx_dout_nxt   = PRIM_ALIGN;
                w_tx_is_k_nxt   = 1'b1;
                // Lock wins over a timeout landing on the same cycle.
                if (w_align_det && (r_align_cnt == LOCK_LAST)) begin
                    w_state_nxt = READY;
                end else begin
                    w_align_cnt_nxt = w_align_det ? r_align_cnt + 4'd1 : 4'd0;
                    if (w_timeout) w_state_nxt = IDLE;
                end
            end
            READY: begin
                w_elec_idle_nxt = 1'b0;
                w_tx_dout_nxt   = PRIM_SYNC;
                w_tx_is_k_nxt   = 1'b1;
                w_linkup_nxt    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        // A fresh host COMRESET restarts the handshake from any active state.
        if (phy.comm_reset_detect &&
            (r_state inside {SEND_INIT, WAIT_WAKE, WAIT_NO_WAKE, SEND_WAKE, SEND_ALIGN, READY})) begin
            w_state_nxt        = WAIT_NO_RESET;
            w_linkup_nxt       = 1'b0;
            w_elec_idle_nxt    = 1'b1;
            w_tx_is_k_nxt      = 1'b0;
            w_timer_nxt        = 32'd0;
            w_tx_comm_init_nxt = 1'b0;
            w_tx_comm_wake_nxt = 1'b0;
        end else if (!phy.platform_ready && (r_state != IDLE)) begin
            w_state_nxt        = IDLE;
            w_linkup_nxt       = 1'b0;
            w_tx_comm_init_nxt = 1'b0;
            w_tx_comm_wake_nxt = 1'b0;
        end
    end

    assign phy.tx_comm_init     = r_tx_comm_init;
    assign phy.tx_comm_wake     = r_tx_comm_wake;
    assign phy.tx_dout          = r_tx_dout;
    assign phy.tx_is_k          = r_tx_is_k;
    assign phy.tx_set_elec_idle = r_elec_idle;
    assign phy.linkup           = r_linkup;
    assign phy.lax_state        = r_state;

endmodule

// File: tb/tb_sata_device_oob_controller.sv
// tb/tb_sata_device_oob_controller.sv - self-checking bench for the device OOB responder
module tb_sata_device_oob_controller;
    import sata_device_oob_controller_pkg::*;

    localparam int AT   = 64;
    localparam int WT   = 64;
    localparam int LOCK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   init_cnt = 0;
    int   wake_cnt = 0;

    sata_device_oob_controller_if ifc();

    sata_device_oob_controller #(
        .WAKE_TIMEOUT (32'd64),
        .ALIGN_TIMEOUT(32'd64),
        .ALIGN_LOCK   (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .phy(ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.tx_comm_init === 1'b1) init_cnt++;
        if (ifc.tx_comm_wake === 1'b1) wake_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // 0: valid ALIGN, 1: random data, 2: ALIGN without byte alignment, 3: ALIGN without K flag
    task automatic set_rx(input int kind);
        case (kind)
            0:       begin ifc.rx_din = PRIM_ALIGN; ifc.rx_is_k = 4'b0001; ifc.rx_byte_is_aligned = 1'b1; end
            2:       begin ifc.rx_din = PRIM_ALIGN; ifc.rx_is_k = 4'b0001; ifc.rx_byte_is_aligned = 1'b0; end
            3:       begin ifc.rx_din = PRIM_ALIGN; ifc.rx_is_k = 4'b0000; ifc.rx_byte_is_aligned = 1'b1; end
            default: begin ifc.rx_din = $urandom; ifc.rx_is_k = 4'($urandom_range(0, 15)); ifc.rx_byte_is_aligned = 1'b1; end
        endcase
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ifc.platform_ready = 1'b0;
        ifc.comm_reset_detect = 1'b0;
        ifc.comm_wake_detect = 1'b0;
        ifc.tx_oob_complete = 1'b0;
        set_rx(1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Walks the OOB handshake; returns positioned just after the edge that enters SEND_ALIGN.
    task automatic go_align(output bit ok);
        int n;
        ifc.platform_ready = 1'b1;
        ifc.comm_reset_detect = 1'b1;
        repeat (10) tick();
        ifc.comm_reset_detect = 1'b0;
        repeat (20) tick();
        ifc.tx_oob_complete = 1'b1;
        tick();
        ifc.tx_oob_complete = 1'b0;
        repeat (5) tick();
        ifc.comm_wake_detect = 1'b1;
        repeat (8) tick();
        ifc.comm_wake_detect = 1'b0;
        repeat (4) tick();
        ifc.tx_oob_complete = 1'b1;
        tick();
        ifc.tx_oob_complete = 1'b0;
        n = 0;
        while (ifc.lax_state !== 4'h6 && n < 10) begin tick(); n++; end
        ok = (ifc.lax_state === 4'h6);
    endtask

    // Reference: edge (1-based from SEND_ALIGN entry) at which the link locks or the ALIGN window expires.
    function automatic int model_lock(input int kinds[$], output bit locked);
        int run = 0;
        locked = 1'b0;
        for (int i = 0; i < kinds.size(); i++) begin
            run = (kinds[i] == 0) ? run + 1 : 0;
            if (run >= LOCK) begin locked = 1'b1; return i + 1; end
            if (i + 1 == AT + 1) return i + 1;
        end
        return kinds.size();
    endfunction

    task automatic run_align_seq(input int kinds[$], input int e,
                                 output logic [3:0] st_before, output logic [3:0] st_at,
                                 output logic lk_at, output logic lk_after,
                                 output logic [31:0] dout_after, output logic isk_after);
        for (int i = 0; i < e - 1; i++) begin set_rx(kinds[i]); tick(); end
        st_before = ifc.lax_state;
        set_rx(kinds[e-1]);
        tick();
        st_at = ifc.lax_state;
        lk_at = ifc.linkup;
        set_rx(1);
        tick();
        lk_after   = ifc.linkup;
        dout_after = ifc.tx_dout;
        isk_after  = ifc.tx_is_k;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        checks++; if (ifc.lax_state !== 4'h0) begin errors++; $display("FAIL reset_state: got %h expected 0", ifc.lax_state); end
        checks++; if (ifc.tx_set_elec_idle !== 1'b1) begin errors++; $display("FAIL reset_elec_idle: got %b expected 1", ifc.tx_set_elec_idle); end
        checks++; if (ifc.linkup !== 1'b0 || ifc.tx_is_k !== 1'b0) begin errors++; $display("FAIL reset_linkup_isk: got %b%b expected 00", ifc.linkup, ifc.tx_is_k); end
        checks++; if (ifc.tx_dout !== 32'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", ifc.tx_dout); end
        checks++; if (ifc.tx_comm_init !== 1'b0 || ifc.tx_comm_wake !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", ifc.tx_comm_init, ifc.tx_comm_wake); end
    endtask

    task automatic test_handshake;
        int ib, wb, n;
        do_reset();
        ib = init_cnt; wb = wake_cnt;
        ifc.platform_ready = 1'b1;
        ifc.comm_reset_detect = 1'b1;
        repeat (10) tick();
        checks++; if (ifc.lax_state !== 4'h1) begin errors++; $display("FAIL hs_wait_no_reset: got %h expected 1", ifc.lax_state); end
        ifc.comm_reset_detect = 1'b0;
        tick();
        checks++; if (ifc.lax_state !== 4'h2 || ifc.tx_comm_init !== 1'b1) begin errors++; $display("FAIL hs_cominit: got state %h init %b expected 2/1", ifc.lax_state, ifc.tx_comm_init); end
        repeat (19) tick();
        ifc.tx_oob_complete = 1'b1;
        tick();
        ifc.tx_oob_complete = 1'b0;
        checks++; if (ifc.lax_state !== 4'h3) begin errors++; $display("FAIL hs_wait_wake: got %h expected 3", ifc.lax_state); end
        repeat (5) tick();
        ifc.comm_wake_detect = 1'b1;
        repeat (8) tick();
        ifc.comm_wake_detect = 1'b0;
        tick();
        checks++; if (ifc.lax_state !== 4'h5 || ifc.tx_comm_wake !== 1'b1) begin errors++; $display("FAIL hs_comwake: got state %h wake %b expected 5/1", ifc.lax_state, ifc.tx_comm_wake); end
        repeat (3) tick();
        ifc.tx_oob_complete = 1'b1;
        tick();
        ifc.tx_oob_complete = 1'b0;
        n = 0;
        while (ifc.tx_dout !== PRIM_ALIGN && n < 10) begin tick(); n++; end
        checks++; if (ifc.tx_dout !== PRIM_ALIGN || ifc.tx_is_k !== 1'b1 || ifc.tx_set_elec_idle !== 1'b0) begin errors++; $display("FAIL hs_align_tx: got %h k %b idle %b expected ALIGN/1/0", ifc.tx_dout, ifc.tx_is_k, ifc.tx_set_elec_idle); end
        repeat (3) begin set_rx(0); tick(); end
        set_rx(1);
        checks++; if (ifc.lax_state !== 4'h7 || ifc.linkup !== 1'b0) begin errors++; $display("FAIL hs_ready_entry: got state %h linkup %b expected 7/0", ifc.lax_state, ifc.linkup); end
        tick();
        checks++; if (ifc.linkup !== 1'b1) begin errors++; $display("FAIL hs_linkup: got %b expected 1", ifc.linkup); end
        checks++; if (ifc.tx_dout !== PRIM_SYNC || ifc.tx_is_k !== 1'b1) begin errors++; $display("FAIL hs_sync: got %h k %b expected %h/1", ifc.tx_dout, ifc.tx_is_k, PRIM_SYNC); end
        checks++; if (init_cnt - ib !== 1 || wake_cnt - wb !== 1) begin errors++; $display("FAIL hs_pulse_count: got init %0d wake %0d expected 1/1", init_cnt - ib, wake_cnt - wb); end
    endtask

    task automatic test_wake_timeout;
        int wb, n;
        do_reset();
        wb = wake_cnt;
        ifc.platform_ready = 1'b1;
        ifc.comm_reset_detect = 1'b1;
        repeat (10) tick();
        ifc.comm_reset_detect = 1'b0;
        repeat (20) tick();
        ifc.tx_oob_complete = 1'b1;
        tick();
        ifc.tx_oob_complete = 1'b0;
        checks++; if (ifc.lax_state !== 4'h3) begin errors++; $display("FAIL wt_enter: got %h expected 3", ifc.lax_state); end
        n = 0;
        while (ifc.lax_state !== 4'h0 && n < 300) begin tick(); n++; end
        checks++; if (n !== WT + 1) begin errors++; $display("FAIL wt_cycles: got %0d expected %0d", n, WT + 1); end
        checks++; if (ifc.linkup !== 1'b0 || wake_cnt - wb !== 0) begin errors++; $display("FAIL wt_side_effects: got linkup %b wakes %0d expected 0/0", ifc.linkup, wake_cnt - wb); end
    endtask

    task automatic check_align_case(input int kinds[$], input string nm);
        bit ok, locked;
        int e;
        logic [3:0] sb, sa;
        logic la, lf, kf;
        logic [31:0] df;
        do_reset();
        go_align(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_reach_align: got %b expected 1", nm, ok); end
        e = model_lock(kinds, locked);
        run_align_seq(kinds, e, sb, sa, la, lf, df, kf);
        checks++; if (sb !== 4'h6) begin errors++; $display("FAIL %s_early_exit: got %h expected 6", nm, sb); end
        checks++; if (sa !== (locked ? 4'h7 : 4'h0)) begin errors++; $display("FAIL %s_state_edge%0d: got %h expected %h", nm, e, sa, locked ? 4'h7 : 4'h0); end
        checks++; if (la !== 1'b0 || lf !== locked) begin errors++; $display("FAIL %s_linkup: got %b,%b expected 0,%b", nm, la, lf, locked); end
        checks++; if (kf !== locked) begin errors++; $display("FAIL %s_is_k: got %b expected %b", nm, kf, locked); end
        if (locked) begin
            checks++; if (df !== PRIM_SYNC) begin errors++; $display("FAIL %s_sync: got %h expected %h", nm, df, PRIM_SYNC); end
        end
    endtask

    task automatic test_align_lock;
        int pats[3][6] = '{'{0, 0, 1, 0, 0, 0}, '{0, 2, 0, 0, 0, 1}, '{0, 0, 3, 0, 0, 0}};
        int kinds[$];
        int p;
        for (int t = 0; t < 3; t++) begin
            kinds = {};
            for (int i = 0; i < 6; i++) kinds.push_back(pats[t][i]);
            while (kinds.size() < AT + 1) kinds.push_back(1);
            check_align_case(kinds, "lock_dir");
        end
        for (int t = 0; t < 8; t++) begin
            kinds = {};
            p = $urandom_range(5, 60);
            for (int i = 0; i < AT + 1; i++)
                kinds.push_back(($urandom_range(0, 99) < p) ? 0 : $urandom_range(1, 3));
            check_align_case(kinds, "lock_rnd");
        end
    endtask

    task automatic test_timeout_priority;
        int kinds[$];
        for (int d = 0; d < 2; d++) begin
            kinds = {};
            for (int i = 0; i < AT + 1 - LOCK + d; i++) kinds.push_back(1);
            while (kinds.size() < AT + 1) kinds.push_back(0);
            check_align_case(kinds, d == 0 ? "prio_lock" : "prio_late");
        end
    endtask

    task automatic test_reset_mid_link;
        bit ok;
        int ib;
        do_reset();
        go_align(ok);
        repeat (LOCK) begin set_rx(0); tick(); end
        set_rx(1);
        tick();
        checks++; if (!ok || ifc.linkup !== 1'b1) begin errors++; $display("FAIL mid_pre_linkup: got ok %b linkup %b expected 1/1", ok, ifc.linkup); end
        ifc.comm_reset_detect = 1'b1;
        tick();
        checks++; if (ifc.lax_state !== 4'h1 || ifc.linkup !== 1'b0) begin errors++; $display("FAIL mid_override: got state %h linkup %b expected 1/0", ifc.lax_state, ifc.linkup); end
        checks++; if (ifc.tx_set_elec_idle !== 1'b1 || ifc.tx_is_k !== 1'b0) begin errors++; $display("FAIL mid_idle_k: got idle %b k %b expected 1/0", ifc.tx_set_elec_idle, ifc.tx_is_k); end
        ifc.comm_reset_detect = 1'b0;
        ib = init_cnt;
        tick();
        #6;
        checks++; if (ifc.lax_state !== 4'h2 || init_cnt - ib !== 1) begin errors++; $display("FAIL mid_new_cominit: got state %h pulses %0d expected 2/1", ifc.lax_state, init_cnt - ib); end
    endtask

    task automatic test_sync_reset;
        bit ok;
        do_reset();
        go_align(ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (ifc.lax_state !== 4'h0 || ifc.tx_dout !== 32'd0 || ifc.tx_is_k !== 1'b0) begin errors++; $display("FAIL srst_state_dout: got %h %h %b expected 0 0 0", ifc.lax_state, ifc.tx_dout, ifc.tx_is_k); end
        checks++; if (ifc.tx_set_elec_idle !== 1'b1 || ifc.linkup !== 1'b0) begin errors++; $display("FAIL srst_idle_link: got %b %b expected 1 0", ifc.tx_set_elec_idle, ifc.linkup); end
        rst = 1'b0;
    endtask

    task automatic test_platform_drop;
        bit ok;
        do_reset();
        go_align(ok);
        tick();
        ifc.platform_ready = 1'b0;
        tick();
        checks++; if (ifc.lax_state !== 4'h0 || ifc.linkup !== 1'b0) begin errors++; $display("FAIL pdrop: got state %h linkup %b expected 0/0", ifc.lax_state, ifc.linkup); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_wake_timeout();
        test_align_lock();
        test_timeout_priority();
        test_reset_mid_link();
        test_sync_reset();
        test_platform_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
